// File: rtl/alarm_sched_cont.sv
// Alarm sequencer: arms, matches CUR_TIME against ALARM_TIME on the 1 s tick, rings, snoozes and times out.
// Optional AUTO_SNOOZE_EN: a ring timeout snoozes automatically until the snooze limit is used up.
module alarm_sched_cont #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int SNOOZE_MAX = 3
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        TICK_1S,
  input  logic [16:0] CUR_TIME,
  input  logic [16:0] ALARM_TIME,
  input  logic        ALARM_EN,
  input  logic        SNOOZE,
  input  logic        STOP,
  output logic        RING,
  output logic [1:0]  STATE,
  output logic [1:0]  SNOOZE_CNT,
  output logic        MATCH
);

  localparam logic [1:0] IDLE     = 2'b00;
  localparam logic [1:0] ARMED    = 2'b01;
  localparam logic [1:0] RINGING  = 2'b10;
  localparam logic [1:0] SNOOZING = 2'b11;

  localparam logic [5:0] RING_LAST   = 6'(RING_SEC - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);
  localparam logic [1:0] SNOOZE_LIM  = 2'(SNOOZE_MAX);

  logic [1:0] state_q, state_d;
  logic [5:0] ring_cnt_q, ring_cnt_d;
  logic [9:0] countdown_q, countdown_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       ring_q, ring_d;
  logic       match_q, match_d;
  logic       time_hit;

  assign time_hit = TICK_1S && (CUR_TIME == ALARM_TIME);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= IDLE;
      ring_cnt_q   <= 6'd0;
      countdown_q  <= 10'd0;
      snooze_cnt_q <= 2'd0;
      ring_q       <= 1'b0;
      match_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      countdown_q  <= countdown_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_q       <= ring_d;
      match_q      <= match_d;
    end
  end

  // Priority: enable off > STOP > SNOOZE > tick. An ignored SNOOZE lets the tick through.
  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    countdown_d  = countdown_q;
    snooze_cnt_d = snooze_cnt_q;
    if (!ALARM_EN) begin
      state_d      = IDLE;
      ring_cnt_d   = 6'd0;
      countdown_d  = 10'd0;
      snooze_cnt_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: begin
          if (time_hit) begin
            state_d      = RINGING;
            ring_cnt_d   = 6'd0;
            snooze_cnt_d = 2'd0;
          end
        end
        RINGING: begin
          if (STOP) begin
            state_d      = ARMED;
            ring_cnt_d   = 6'd0;
            snooze_cnt_d = 2'd0;
          end else if (SNOOZE && (snooze_cnt_q < SNOOZE_LIM)) begin
            state_d      = SNOOZING;
            ring_cnt_d   = 6'd0;
            countdown_d  = SNOOZE_LOAD;
            snooze_cnt_d = snooze_cnt_q + 2'd1;
          end else if (TICK_1S) begin
            if (ring_cnt_q == RING_LAST) begin
              ring_cnt_d = 6'd0;
`ifdef AUTO_SNOOZE_EN
              if (snooze_cnt_q < SNOOZE_LIM) begin
                state_d      = SNOOZING;
                countdown_d  = SNOOZE_LOAD;
                snooze_cnt_d = snooze_cnt_q + 2'd1;
              end else begin
                state_d      = ARMED;
                snooze_cnt_d = 2'd0;
              end
`else
              state_d      = ARMED;
              snooze_cnt_d = 2'd0;
`endif
            end else begin
              ring_cnt_d = ring_cnt_q + 6'd1;
            end
          end
        end
        SNOOZING: begin
          if (STOP) begin
            state_d      = ARMED;
            countdown_d  = 10'd0;
            snooze_cnt_d = 2'd0;
          end else if (TICK_1S) begin
            if (countdown_q == 10'd1) begin
              state_d     = RINGING;
              ring_cnt_d  = 6'd0;
              countdown_d = 10'd0;
            end else if (countdown_q != 10'd0) begin
              countdown_d = countdown_q - 10'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ring_d  = (state_d == RINGING);
    match_d = ALARM_EN && (state_q == ARMED) && time_hit;
  end

  assign STATE      = state_q;
  assign SNOOZE_CNT = snooze_cnt_q;
  assign RING       = ring_q;
  assign MATCH      = match_q;

endmodule

// File: tb/tb_alarm_sched_cont.sv
// Bench for alarm_sched_cont: vector table, hand-written long sequences, and random traffic against a reference model.
module tb_alarm_sched_cont;

  localparam int RING_SEC   = 60;
  localparam int SNOOZE_MIN = 5;
  localparam int SNOOZE_MAX = 3;
  localparam logic [16:0] T7 = {1'b0, 4'd7, 6'd10, 6'd0};
  localparam logic [16:0] TX = {1'b0, 4'd7, 6'd10, 6'd1};
  localparam logic [16:0] T8 = {1'b1, 4'd8, 6'd30, 6'd15};

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        TICK_1S, ALARM_EN, SNOOZE, STOP;
  logic [16:0] CUR_TIME, ALARM_TIME;
  logic        RING, MATCH;
  logic [1:0]  STATE, SNOOZE_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  alarm_sched_cont #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN), .SNOOZE_MAX(SNOOZE_MAX)) dut (
    .CLK(CLK), .RESETN(RESETN), .TICK_1S(TICK_1S), .CUR_TIME(CUR_TIME), .ALARM_TIME(ALARM_TIME),
    .ALARM_EN(ALARM_EN), .SNOOZE(SNOOZE), .STOP(STOP), .RING(RING), .STATE(STATE),
    .SNOOZE_CNT(SNOOZE_CNT), .MATCH(MATCH)
  );

  // Reference model: mode plus seconds remaining in the ring / snooze windows.
  int m_mode;       // 0 idle, 1 armed, 2 ringing, 3 snoozing
  int m_ring_left;
  int m_snz_left;
  int m_used;
  bit m_match;

  function automatic void model_reset();
    m_mode = 0; m_ring_left = 0; m_snz_left = 0; m_used = 0; m_match = 0;
  endfunction

  function automatic void start_snooze();
    m_used++;
    m_snz_left = SNOOZE_MIN * 60;
    m_mode = 3;
  endfunction

  function automatic void model_step(input logic en, tick, snz, stp, input logic [16:0] cur, alm);
    m_match = 0;
    if (!en) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (tick && cur == alm) begin
           m_mode = 2; m_match = 1; m_ring_left = RING_SEC; m_used = 0;
         end
      2: if (stp) begin
           m_mode = 1; m_used = 0;
         end else if (snz && m_used < SNOOZE_MAX) begin
           start_snooze();
         end else if (tick) begin
           m_ring_left--;
           if (m_ring_left == 0) begin
`ifdef AUTO_SNOOZE_EN
             if (m_used < SNOOZE_MAX) start_snooze();
             else begin m_mode = 1; m_used = 0; end
`else
             m_mode = 1; m_used = 0;
`endif
           end
         end
      default: if (stp) begin
           m_mode = 1; m_used = 0;
         end else if (tick) begin
           if (m_snz_left > 0) m_snz_left--;
           if (m_snz_left == 0) begin m_mode = 2; m_ring_left = RING_SEC; end
         end
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic rg, input logic [1:0] sc, input logic mt);
    chk({tag, ".STATE"}, 32'(STATE), 32'(st));
    chk({tag, ".RING"}, 32'(RING), 32'(rg));
    chk({tag, ".SNOOZE_CNT"}, 32'(SNOOZE_CNT), 32'(sc));
    chk({tag, ".MATCH"}, 32'(MATCH), 32'(mt));
  endtask

  // One clock: drive, edge, advance the model, compare.
  task automatic cyc(input logic en, tick, snz, stp, input logic [16:0] cur, alm);
    ALARM_EN = en; TICK_1S = tick; SNOOZE = snz; STOP = stp; CUR_TIME = cur; ALARM_TIME = alm;
    @(posedge CLK);
    #1;
    model_step(en, tick, snz, stp, cur, alm);
    expect_out("model", 2'(m_mode), logic'(m_mode == 2), 2'(m_used), logic'(m_match));
  endtask

  task automatic ticks(input int n, input logic [16:0] alm);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, TX, alm);
  endtask

  typedef struct {
    logic en, tick, snz, stp;
    logic [16:0] cur, alm;
    logic [1:0] st;
    logic rg;
    logic [1:0] sc;
    logic mt;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic en, tick, snz, stp, input logic [16:0] cur, alm,
                              input logic [1:0] st, input logic rg, input logic [1:0] sc, input logic mt);
    tbl.push_back('{en, tick, snz, stp, cur, alm, st, rg, sc, mt});
  endfunction

  initial begin
    logic [16:0] alm_r;
    RESETN = 1'b0; ALARM_EN = 1'b0; TICK_1S = 1'b0; SNOOZE = 1'b0; STOP = 1'b0;
    CUR_TIME = 17'd0; ALARM_TIME = T7;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    expect_out("reset", 2'b00, 1'b0, 2'd0, 1'b0);
    @(negedge CLK);
    RESETN = 1'b1;

    //   en    tick  snz   stp   cur alm  state  ring  scnt  match
    add(1'b1, 1'b0, 1'b0, 1'b0, TX, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, TX, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, T7, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T7, 2'b10, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b0, 1'b0, 1'b0, T7, T7, 2'b10, 1'b1, 2'd0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, TX, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T7, 2'b10, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, TX, T7, 2'b11, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b0, TX, T7, 2'b11, 1'b0, 2'd1, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b1, TX, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T7, 2'b10, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b0, 1'b1, 1'b0, TX, T7, 2'b11, 1'b0, 2'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, TX, T7, 2'b00, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T7, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T8, 2'b01, 1'b0, 2'd0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, T8, T8, 2'b10, 1'b1, 2'd0, 1'b1);
    add(1'b1, 1'b1, 1'b0, 1'b0, T7, T7, 2'b10, 1'b1, 2'd0, 1'b0);
    add(1'b0, 1'b0, 1'b0, 1'b0, TX, T7, 2'b00, 1'b0, 2'd0, 1'b0);
    foreach (tbl[i]) begin
      cyc(tbl[i].en, tbl[i].tick, tbl[i].snz, tbl[i].stp, tbl[i].cur, tbl[i].alm);
      expect_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].rg, tbl[i].sc, tbl[i].mt);
    end

    // Ring timeout.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, TX, T7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, T7, T7);
    ticks(RING_SEC - 1, T7);
    expect_out("timeout_pre", 2'b10, 1'b1, 2'd0, 1'b0);
    ticks(1, T7);
`ifdef AUTO_SNOOZE_EN
    expect_out("timeout", 2'b11, 1'b0, 2'd1, 1'b0);
    ticks(SNOOZE_MIN * 60, T7);
    expect_out("auto_rering", 2'b10, 1'b1, 2'd1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, TX, T7);
`else
    expect_out("timeout", 2'b01, 1'b0, 2'd0, 1'b0);
`endif

    // Snooze until the limit, then an extra snooze is ignored.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, T7, T7);
    expect_out("snz_trig", 2'b10, 1'b1, 2'd0, 1'b1);
    for (int k = 1; k <= SNOOZE_MAX; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0, TX, T7);
      expect_out($sformatf("snz%0d", k), 2'b11, 1'b0, 2'(k), 1'b0);
      ticks(SNOOZE_MIN * 60 - 1, T7);
      expect_out($sformatf("snz%0d_wait", k), 2'b11, 1'b0, 2'(k), 1'b0);
      ticks(1, T7);
      expect_out($sformatf("snz%0d_rering", k), 2'b10, 1'b1, 2'(k), 1'b0);
    end
    cyc(1'b1, 1'b0, 1'b1, 1'b0, TX, T7);
    expect_out("snz_limit", 2'b10, 1'b1, 2'd3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, TX, T7);
    expect_out("snz_stop", 2'b01, 1'b0, 2'd0, 1'b0);

    // Asynchronous reset mid-ring.
    cyc(1'b1, 1'b1, 1'b0, 1'b0, T7, T7);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, TX, T7);
    ticks(SNOOZE_MIN * 60, T7);
    expect_out("pre_rst", 2'b10, 1'b1, 2'd1, 1'b0);
    #2 RESETN = 1'b0;
    #1;
    expect_out("async_rst", 2'b00, 1'b0, 2'd0, 1'b0);
    @(posedge CLK);
    #1 RESETN = 1'b1;
    model_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, TX, T7);
    expect_out("post_rst", 2'b01, 1'b0, 2'd0, 1'b0);

    // Random traffic against the model.
    alm_r = T7;
    for (int n = 0; n < 6000; n++) begin
      logic en, tick, snz, stp;
      logic [16:0] cur;
      if ($urandom_range(0, 299) == 0) alm_r = ($urandom_range(0, 1) == 0) ? T7 : 17'($urandom);
      en   = ($urandom_range(0, 399) != 0);
      tick = ($urandom_range(0, 1) == 0);
      snz  = ($urandom_range(0, 39) == 0);
      stp  = ($urandom_range(0, 249) == 0);
      cur  = ($urandom_range(0, 3) == 0) ? alm_r : 17'($urandom);
      cyc(en, tick, snz, stp, cur, alm_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
